instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter PC_W, default 8, SHALL set the program counter and instruction-memory address width.
REQ-002 Parameter TIMEOUT_CYC, default 15, SHALL set the fetch-timeout limit in cycles (used only under REQ-030).
REQ-003 Port clk, in, 1: SHALL be the single clock; all state SHALL update on the rising edge.
REQ-004 Port clr, in, 1: SHALL be the asynchronous, active-low reset.
REQ-005 Port en_fetch, in, 1: SHALL be the fetch request from the control unit.
REQ-006 Port inst_en, in, 6: SHALL carry the load enables {PC_EN, INST_EN, ADDR_EN, Y_EN, OP_EN, X_EN}, MSB first.
REQ-007 Port branch, in, 1: SHALL be the PC load strobe.
REQ-008 Port branch_addr, in, PC_W: SHALL be the PC load target.
REQ-009 Port imem_req, out, 1: SHALL be the instruction-memory read request.
REQ-010 Port imem_addr, out, PC_W: SHALL be the read address, equal to pc.
REQ-011 Port imem_ack, in, 1: SHALL signal valid read data.
REQ-012 Port imem_rdata, in, 16: SHALL be the instruction word.
REQ-013 Ports op (3), x (3), y (2), addr (8), out: SHALL be the registered decoded fields feeding the control unit and datapath.
REQ-014 Port pc, out, PC_W: SHALL be the current program counter.
REQ-015 Port inst_valid, out, 1: SHALL indicate that the IR holds an unconsumed instruction.
REQ-016 Port fetch_err, out, 1: SHALL be a one-cycle timeout pulse.

Function
REQ-017 FSM: states IDLE, REQ, READY; transitions IDLE->REQ on en_fetch=1, REQ->READY on imem_ack=1 (or timeout), READY->IDLE on PC_EN=1.
REQ-018 imem_req SHALL be 1 exactly while in REQ, SHALL be driven combinationally from state, and imem_addr SHALL stay stable until ack.
REQ-019 An en_fetch deassert while in REQ SHALL NOT abort the request; there is no cancel.
REQ-020 On the imem_ack edge in REQ, IR <= imem_rdata; imem_ack outside REQ SHALL be ignored.
REQ-021 Latency: en_fetch sampled at edge t0 and ack during the first REQ cycle SHALL give inst_valid=1 after edge t0+1.
REQ-022 inst_valid SHALL be 1 exactly in READY.
REQ-023 Field split: op=IR[15:13], x=IR[12:10], y=IR[9:8], addr=IR[7:0].
REQ-024 In READY each field register SHALL load from IR on the edge where its enable (OP_EN, X_EN, Y_EN, ADDR_EN) is 1; otherwise it SHALL hold.
REQ-025 In READY, when INST_EN=1, all four fields SHALL load regardless of the individual enables.
REQ-026 PC update in READY with PC_EN=1: branch=1 SHALL give pc <= branch_addr; otherwise pc <= pc+1 modulo 2^PC_W (all-ones SHALL wrap to 0).
REQ-027 branch, PC_EN and field enables outside READY SHALL be ignored; pc SHALL never change in REQ.
REQ-028 PC_EN together with field enables on the same edge SHALL apply both: fields SHALL load from the current IR, then the state SHALL go to IDLE.

Reset
REQ-029 clr=0 SHALL immediately force state IDLE, pc=0, IR=0, op/x/y/addr=0, imem_req=0, inst_valid=0, fetch_err=0 and timeout count 0, including mid-REQ; any ack arriving during reset SHALL be discarded.

Configuration
REQ-030 With FETCH_TIMEOUT_EN defined, a counter SHALL count REQ cycles without ack; at TIMEOUT_CYC consecutive cycles, fetch_err SHALL pulse for 1 cycle, IR <= 16'h0000 (op 000), and the state SHALL go to READY; the counter SHALL clear on entry to REQ.
REQ-031 Without FETCH_TIMEOUT_EN, REQ SHALL wait indefinitely, fetch_err SHALL be tied to 0, and no counter logic SHALL exist.

Structure
REQ-032 Package instr_pkg SHALL hold the state enum, the field widths and bit positions, the inst_en bit index constants, and the NOP opcode constant.
REQ-033 The timeout counter SHALL be a sub-module fetch_timer (inputs: count enable, clear; output: expired), instantiated only under FETCH_TIMEOUT_EN.

Verification
REQ-034 Reset, then en_fetch=1 with imem_rdata=16'hA5C3 and ack on the first REQ cycle -> imem_addr=0, inst_valid=1 one edge later; inst_en=6'b010000 -> op=3'b101, x=3'b001, y=2'b01, addr=8'hC3.
REQ-035 inst_en=6'b100000 in READY with branch=0, pc=8'hFF -> pc=8'h00, state IDLE, inst_valid=0.
REQ-036 PC_EN=1 with branch=1 and branch_addr=8'h40 -> pc=8'h40; the next fetch drives imem_addr=8'h40.
REQ-037 Ack delayed by 5 cycles while en_fetch drops after 1 cycle -> imem_req held high for 6 cycles with a stable address, then IR captured.
REQ-038 clr=0 asserted mid-REQ with ack on the same cycle -> imem_req=0 immediately; after release, pc=0, fields=0, IR not loaded.
REQ-039 FETCH_TIMEOUT_EN with no ack -> fetch_err pulses on the 15th REQ cycle, op=3'b000, inst_valid=1; without the macro -> imem_req stays high and fetch_err=0.

Source files
------------

// File: rtl/instr_pkg.sv
// Shared types and constants for the instruction fetch unit: FSM states,
// IR field layout, inst_en bit positions and the NOP opcode.
package instr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_READY = 2'd2
    } fetch_state_e;

    localparam int IR_W   = 16;
    localparam int OP_W   = 3;
    localparam int X_W    = 3;
    localparam int Y_W    = 2;
    localparam int ADDR_W = 8;

    localparam int OP_MSB   = 15;
    localparam int OP_LSB   = 13;
    localparam int X_MSB    = 12;
    localparam int X_LSB    = 10;
    localparam int Y_MSB    = 9;
    localparam int Y_LSB    = 8;
    localparam int ADDR_MSB = 7;
    localparam int ADDR_LSB = 0;

    // inst_en = {PC_EN, INST_EN, ADDR_EN, Y_EN, OP_EN, X_EN}
    localparam int IEN_PC   = 5;
    localparam int IEN_INST = 4;
    localparam int IEN_ADDR = 3;
    localparam int IEN_Y    = 2;
    localparam int IEN_OP   = 1;
    localparam int IEN_X    = 0;

    localparam logic [OP_W-1:0] OP_NOP = 3'b000;

endpackage

// File: rtl/fetch_timer.sv
// Counts consecutive enabled cycles; expired is high on the LIMIT-th one.
// Used by instr_fetch only when FETCH_TIMEOUT_EN is defined.
module fetch_timer #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cnt_en,
    input  logic clr,
    output logic expired
);
    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_r;

    // Cycle counter, cleared on each new request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CW{1'b0}};
        end else if (clr) begin
            cnt_r <= {CW{1'b0}};
        end else if (cnt_en) begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    assign expired = cnt_en && (cnt_r == CW'(LIMIT - 1));

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: IDLE/REQ/READY handshake with instruction memory,
// IR capture, field decode and PC update. Optional timeout: FETCH_TIMEOUT_EN.
module instr_fetch
    import instr_pkg::*;
#(
    parameter int PC_W        = 8,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              en_fetch,
    input  logic [5:0]        inst_en,
    input  logic              branch,
    input  logic [PC_W-1:0]   branch_addr,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [IR_W-1:0]   imem_rdata,
    output logic [OP_W-1:0]   op,
    output logic [X_W-1:0]    x,
    output logic [Y_W-1:0]    y,
    output logic [ADDR_W-1:0] addr,
    output logic [PC_W-1:0]   pc,
    output logic              inst_valid,
    output logic              fetch_err
);
    fetch_state_e      state_r;
    logic [IR_W-1:0]   ir_r;
    logic [PC_W-1:0]   pc_r;
    logic [OP_W-1:0]   op_r;
    logic [X_W-1:0]    x_r;
    logic [Y_W-1:0]    y_r;
    logic [ADDR_W-1:0] addr_r;
    logic              fetch_err_r;
    logic              timeout_s;
    logic              load_all_s;

`ifdef FETCH_TIMEOUT_EN
    logic cnt_en_s;
    logic cnt_clr_s;

    assign cnt_en_s  = (state_r == ST_REQ) && !imem_ack;
    assign cnt_clr_s = (state_r == ST_IDLE) && en_fetch;

    fetch_timer #(
        .LIMIT   (TIMEOUT_CYC)
    ) u_fetch_timer (
        .clk     (clk),
        .rst_n   (clr),
        .cnt_en  (cnt_en_s),
        .clr     (cnt_clr_s),
        .expired (timeout_s)
    );
`else
    assign timeout_s = 1'b0;
`endif

    assign load_all_s = inst_en[IEN_INST];

    // Fetch FSM with IR, decoded fields and PC held as registered state.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_r     <= ST_IDLE;
            ir_r        <= {IR_W{1'b0}};
            pc_r        <= {PC_W{1'b0}};
            op_r        <= {OP_W{1'b0}};
            x_r         <= {X_W{1'b0}};
            y_r         <= {Y_W{1'b0}};
            addr_r      <= {ADDR_W{1'b0}};
            fetch_err_r <= 1'b0;
        end else begin
            fetch_err_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (en_fetch) begin
                        state_r <= ST_REQ;
                    end
                end
                // No cancel path: en_fetch is ignored until ack or timeout.
                ST_REQ: begin
                    if (imem_ack) begin
                        ir_r    <= imem_rdata;
                        state_r <= ST_READY;
                    end else if (timeout_s) begin
                        ir_r        <= {OP_NOP, {(IR_W-OP_W){1'b0}}};
                        fetch_err_r <= 1'b1;
                        state_r     <= ST_READY;
                    end
                end
                ST_READY: begin
                    if (load_all_s || inst_en[IEN_OP]) begin
                        op_r <= ir_r[OP_MSB:OP_LSB];
                    end
                    if (load_all_s || inst_en[IEN_X]) begin
                        x_r <= ir_r[X_MSB:X_LSB];
                    end
                    if (load_all_s || inst_en[IEN_Y]) begin
                        y_r <= ir_r[Y_MSB:Y_LSB];
                    end
                    if (load_all_s || inst_en[IEN_ADDR]) begin
                        addr_r <= ir_r[ADDR_MSB:ADDR_LSB];
                    end
                    if (inst_en[IEN_PC]) begin
                        pc_r    <= branch ? branch_addr
                                          : pc_r + {{(PC_W-1){1'b0}}, 1'b1};
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign imem_req   = (state_r == ST_REQ);
    assign inst_valid = (state_r == ST_READY);
    assign imem_addr  = pc_r;
    assign pc         = pc_r;
    assign op         = op_r;
    assign x          = x_r;
    assign y          = y_r;
    assign addr       = addr_r;
    assign fetch_err  = fetch_err_r;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: random fetch transactions against a
// queue-based reference model, plus directed reset and stall scenarios.
module tb_instr_fetch;

    logic        clk;
    logic        clr;
    logic        en_fetch;
    logic [5:0]  inst_en;
    logic        branch;
    logic [7:0]  branch_addr;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [2:0]  op;
    logic [2:0]  x;
    logic [1:0]  y;
    logic [7:0]  addr;
    logic [7:0]  pc;
    logic        inst_valid;
    logic        fetch_err;

    instr_fetch #(.PC_W(8), .TIMEOUT_CYC(15)) dut (
        .clk         (clk),
        .clr         (clr),
        .en_fetch    (en_fetch),
        .inst_en     (inst_en),
        .branch      (branch),
        .branch_addr (branch_addr),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .op          (op),
        .x           (x),
        .y           (y),
        .addr        (addr),
        .pc          (pc),
        .inst_valid  (inst_valid),
        .fetch_err   (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: architectural state only.
    logic [7:0]  m_pc;
    logic [15:0] m_ir;
    logic [2:0]  m_op;
    logic [2:0]  m_x;
    logic [1:0]  m_y;
    logic [7:0]  m_addr;

    typedef struct {
        logic [7:0] addr;
        int         cycles;
    } req_t;

    typedef struct {
        logic [7:0]  pc;
        logic [15:0] fields;
    } done_t;

    req_t  req_q[$];
    done_t done_q[$];

    function automatic void model_fields(input logic [5:0] en);
        bit all;
        all = en[4];
        if (all || en[1]) m_op   = 3'((m_ir / 16'd8192) % 16'd8);
        if (all || en[0]) m_x    = 3'((m_ir / 16'd1024) % 16'd8);
        if (all || en[2]) m_y    = 2'((m_ir / 16'd256) % 16'd4);
        if (all || en[3]) m_addr = 8'(m_ir % 16'd256);
    endfunction

    // Monitor: checks request address/duration and state after each consumed instruction.
    bit         mon_on;
    logic       prev_req;
    logic       prev_valid;
    int         req_cyc;
    logic [7:0] req_addr;
    req_t       cur_req;
    done_t      cur_done;

    initial begin
        mon_on     = 1'b0;
        prev_req   = 1'b0;
        prev_valid = 1'b0;
        req_cyc    = 0;
        req_addr   = 8'h00;
        cur_req    = '{8'h00, 0};
        forever begin
            @(negedge clk);
            if (mon_on) begin
                if (imem_req && !prev_req) begin
                    if (req_q.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL unexpected_req: got addr %0h expected no request", imem_addr);
                    end else begin
                        cur_req = req_q.pop_front();
                        check("imem_addr", imem_addr, cur_req.addr);
                    end
                    req_cyc  = 1;
                    req_addr = imem_addr;
                end else if (imem_req) begin
                    req_cyc++;
                    check("addr_stable", imem_addr, req_addr);
                end
                if (!imem_req && prev_req) check("req_cycles", req_cyc, cur_req.cycles);
                if (!inst_valid && prev_valid) begin
                    if (done_q.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL unexpected_consume: got pc %0h expected no consume", pc);
                    end else begin
                        cur_done = done_q.pop_front();
                        check("pc", pc, cur_done.pc);
                        check("fields", {op, x, y, addr}, cur_done.fields);
                    end
                end
`ifndef FETCH_TIMEOUT_EN
                check("fetch_err_idle", fetch_err, 1'b0);
`endif
            end
            prev_req   = imem_req;
            prev_valid = inst_valid;
        end
    end

    // One fetch: request with ack after dly stall cycles, n_mid partial loads, then consume.
    task automatic fetch_txn(input logic [15:0] word, input int dly, input int n_mid,
                             input logic do_br, input logic [7:0] baddr, input logic [4:0] fin_en);
        logic [5:0] en;
        req_q.push_back('{m_pc, dly + 1});
        en_fetch = 1'b1;
        inst_en  = 6'($urandom_range(0, 63));
        branch   = 1'($urandom_range(0, 1));
        branch_addr = 8'($urandom);
        @(posedge clk); #1;
        en_fetch = 1'b0;
        for (int i = 0; i < dly; i++) begin
            inst_en = 6'($urandom_range(0, 63));
            branch  = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        check("valid_before_ack", inst_valid, 1'b0);
        imem_ack   = 1'b1;
        imem_rdata = word;
        @(posedge clk); #1;
        check("valid_latency", inst_valid, 1'b1);
        m_ir       = word;
        imem_ack   = 1'b0;
        imem_rdata = 16'($urandom);
        branch     = 1'b0;
        for (int i = 0; i < n_mid; i++) begin
            en       = {1'b0, 5'($urandom_range(0, 31))};
            inst_en  = en;
            imem_ack = 1'($urandom_range(0, 1));
            model_fields(en);
            @(posedge clk); #1;
        end
        en          = {1'b1, fin_en};
        inst_en     = en;
        branch      = do_br;
        branch_addr = baddr;
        imem_ack    = 1'b0;
        model_fields(en);
        m_pc = do_br ? baddr : 8'(m_pc + 8'd1);
        done_q.push_back('{m_pc, {m_op, m_x, m_y, m_addr}});
        @(posedge clk); #1;
        inst_en = 6'b000000;
        branch  = 1'b0;
    endtask

    initial begin
        clr = 1'b0; en_fetch = 1'b0; inst_en = 6'b000000; branch = 1'b0;
        branch_addr = 8'h00; imem_ack = 1'b0; imem_rdata = 16'h0000;
        m_pc = 8'h00; m_ir = 16'h0000; m_op = 3'b000; m_x = 3'b000; m_y = 2'b00; m_addr = 8'h00;

        repeat (2) @(posedge clk);
        #1;
        check("rst_pc", pc, 8'h00);
        check("rst_fields", {op, x, y, addr}, 16'h0000);
        check("rst_req", imem_req, 1'b0);
        check("rst_valid", inst_valid, 1'b0);
        check("rst_err", fetch_err, 1'b0);
        clr    = 1'b1;
        mon_on = 1'b1;
        @(posedge clk); #1;

        fetch_txn(16'hA5C3, 0, 0, 1'b0, 8'h00, 5'b10000);
        check("dir_op", op, 3'b101);
        check("dir_x", x, 3'b001);
        check("dir_y", y, 2'b01);
        check("dir_addr", addr, 8'hC3);

        fetch_txn(16'h1234, 5, 1, 1'b1, 8'h40, 5'b00000);
        check("dir_branch_pc", pc, 8'h40);
        fetch_txn(16'h5678, 2, 0, 1'b1, 8'hFF, 5'b00000);
        fetch_txn(16'h9ABC, 1, 2, 1'b0, 8'h00, 5'b00011);
        check("dir_wrap_pc", pc, 8'h00);
        check("dir_wrap_valid", inst_valid, 1'b0);

        for (int t = 0; t < 40; t++) begin
            fetch_txn(16'($urandom), int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), 8'($urandom), 5'($urandom_range(0, 31)));
            repeat (int'($urandom_range(0, 2))) @(posedge clk);
            #0;
        end

        @(negedge clk); #1;
        mon_on = 1'b0;
        check("req_q_drained", req_q.size(), 0);
        check("done_q_drained", done_q.size(), 0);

        // Reset while in REQ with an ack on the same cycle.
        @(posedge clk); #1;
        en_fetch = 1'b1;
        @(posedge clk); #1;
        en_fetch = 1'b0;
        check("pre_rst_req", imem_req, 1'b1);
        imem_ack = 1'b1; imem_rdata = 16'hFFFF; clr = 1'b0;
        #1;
        check("async_rst_req", imem_req, 1'b0);
        @(posedge clk); #1;
        clr = 1'b1; imem_ack = 1'b0;
        @(negedge clk);
        check("post_rst_pc", pc, 8'h00);
        check("post_rst_fields", {op, x, y, addr}, 16'h0000);
        check("post_rst_valid", inst_valid, 1'b0);
        check("post_rst_req", imem_req, 1'b0);

        // No ack: request must hold (or time out when the feature is built in).
        @(posedge clk); #1;
        en_fetch = 1'b1;
        @(posedge clk); #1;
        en_fetch = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        begin
            int err_at;
            err_at = -1;
            for (int c = 1; c <= 20; c++) begin
                @(negedge clk);
                if (fetch_err && err_at < 0) begin
                    err_at = c;
                    check("to_op", op, 3'b000);
                    check("to_valid", inst_valid, 1'b1);
                end
            end
            check("to_cycle", err_at, 16);
        end
`else
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            check("stall_req", imem_req, 1'b1);
            check("stall_err", fetch_err, 1'b0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
